// File: rtl/serial_sub_if.sv
// serial_sub_if: operand/result handshake bundle for serial_sub
//   master: drives in_valid, a, b, out_ready; observes in_ready and the result
//   slave:  accepts operands, returns diff/borrow/overflow/zero under out_valid
interface serial_sub_if #(parameter int WIDTH = 32) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             overflow;
   logic             zero;
   modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, diff, borrow, overflow, zero);
   modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, diff, borrow, overflow, zero);
endinterface

// File: rtl/serial_sub.sv
// serial_sub: multi-cycle a - b, one DIGIT-bit slice per clock with a registered borrow chain
//   clk, rst_n (async active-low); bus (slave): in_valid/in_ready + a, b in; out_valid/out_ready + diff, borrow, overflow, zero out
module serial_sub #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input logic         clk,
   input logic         rst_n,
   serial_sub_if.slave bus
);
   localparam int N = WIDTH / DIGIT;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] a_q, b_q, res, diff_n;
   logic [CW-1:0]    k;
   logic [IW-1:0]    idx;
   logic [DIGIT:0]   sum;
   logic             carry;
   logic             last;
   assign idx = IW'(k * DIGIT);
   assign last = k == LAST;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   always_comb
      state_n = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                                (bus.out_ready ? IDLE : DONE);
   always_comb begin
      bus.in_ready = state == IDLE;
      bus.out_valid = state == DONE;
   end
   // carry starts at 1 so each slice computes a + ~b + 1 across the whole word
   always_comb begin
      sum = {1'b0, a_q[idx +: DIGIT]} + {1'b0, ~b_q[idx +: DIGIT]} + (DIGIT + 1)'(carry);
      diff_n = res;
      diff_n[idx +: DIGIT] = sum[DIGIT-1:0];
   end
   // outputs only load on the last slice, so a partial result is never visible
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         res <= '0;
         k <= '0;
         carry <= 1'b0;
         bus.diff <= '0;
         bus.borrow <= 1'b0;
         bus.overflow <= 1'b0;
         bus.zero <= 1'b0;
      end else if (state == IDLE && bus.in_valid) begin
         a_q <= bus.a;
         b_q <= bus.b;
         k <= '0;
         carry <= 1'b1;
      end else if (state == RUN) begin
         res <= diff_n;
         carry <= sum[DIGIT];
         k <= k + 1'b1;
         if (last) begin
            bus.diff <= diff_n;
            bus.borrow <= ~sum[DIGIT];
            bus.overflow <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_n[WIDTH-1] != a_q[WIDTH-1]);
            bus.zero <= diff_n == '0;
         end
      end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: drives DIGIT=8, 1 and 32 instances in lockstep against an arithmetic reference
module tb_serial_sub;
   localparam int DG[3] = '{8, 1, 32};
   localparam int NN[3] = '{4, 32, 1};
   logic clk = 1'b0;
   logic rst_n, in_valid, out_ready;
   logic [31:0] a, b;
   logic rdy[3], ov[3], brw[3], ovf[3], zr[3];
   logic [31:0] dif[3];
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : u
      serial_sub_if #(.WIDTH(32)) bus ();
      assign bus.in_valid = in_valid;
      assign bus.a = a;
      assign bus.b = b;
      assign bus.out_ready = out_ready;
      assign rdy[g] = bus.in_ready;
      assign ov[g] = bus.out_valid;
      assign dif[g] = bus.diff;
      assign brw[g] = bus.borrow;
      assign ovf[g] = bus.overflow;
      assign zr[g] = bus.zero;
      serial_sub #(.WIDTH(32), .DIGIT(DG[g])) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   end
   task automatic chk(input string tag, input int j, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s[d%0d] got=%0h exp=%0h", tag, DG[j], got, exp);
      end
   endtask
   task automatic chk_reset();
      for (int j = 0; j < 3; j++) begin
         chk("rst_in_ready", j, 32'(rdy[j]), 32'd1);
         chk("rst_out_valid", j, 32'(ov[j]), 32'd0);
         chk("rst_diff", j, dif[j], 32'd0);
         chk("rst_flags", j, {29'd0, brw[j], ovf[j], zr[j]}, 32'd0);
      end
   endtask
   task automatic op(input logic [31:0] av, input logic [31:0] bv, input bit hold);
      logic [32:0] w;
      longint r;
      logic [31:0] ed;
      logic [2:0] ef;
      int lat[3];
      int c;
      w = {1'b0, av} - {1'b0, bv};
      ed = w[31:0];
      r = longint'($signed(av)) - longint'($signed(bv));
      ef = {w[32], r > 64'sd2147483647 || r < -64'sd2147483648, ed == 32'd0};
      @(negedge clk);
      for (int j = 0; j < 3; j++) chk("idle_ready", j, 32'(rdy[j]), 32'd1);
      in_valid = 1'b1;
      a = av;
      b = bv;
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      lat = '{0, 0, 0};
      c = 0;
      while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && c < 40) begin
         @(negedge clk);
         c++;
         for (int j = 0; j < 3; j++) if (lat[j] == 0 && ov[j]) lat[j] = c;
      end
      for (int j = 0; j < 3; j++) begin
         chk("latency", j, 32'(lat[j]), 32'(NN[j]));
         chk("diff", j, dif[j], ed);
         chk("flags", j, {29'd0, brw[j], ovf[j], zr[j]}, {29'd0, ef});
      end
      if (hold) begin
         for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
               chk("hold_diff", j, dif[j], ed);
               chk("hold_flags", j, {29'd0, brw[j], ovf[j], zr[j]}, {29'd0, ef});
               chk("hold_ready", j, {30'd0, rdy[j], ov[j]}, 32'd1);
            end
         end
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      for (int j = 0; j < 3; j++) chk("post_handshake", j, {30'd0, rdy[j], ov[j]}, 32'd2);
   endtask
   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      @(negedge clk);
      chk_reset();
      @(negedge clk);
      rst_n = 1'b1;
      op(32'h00000005, 32'h00000003, 1'b0);
      op(32'h00000000, 32'h00000001, 1'b0);
      op(32'h12345678, 32'h12345678, 1'b0);
      op(32'h80000000, 32'h00000001, 1'b0);
      op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
      op(32'h00FF0000, 32'h0000FF00, 1'b0);
      op(32'h0000FF00, 32'h00FF0000, 1'b1);
      for (int i = 0; i < 12; i++) op($urandom, $urandom, i % 4 == 0);
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h00000005;
      b = 32'h00000003;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset();
      @(negedge clk);
      rst_n = 1'b1;
      op(32'h00000005, 32'h00000003, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
